// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type, default operand width and counter-width helper
// for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      CARRY = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int WIDTH_DEF = 8;

   // The bit counter must still exist when WIDTH is 1, so it is never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_piso_register.sv
// piso_register: parallel-in serial-out shift register, LSB first.
// Ports: clk, rst (async, active-high, clears contents), load_i (parallel load, wins over shift),
//        shift_i (shift right with zero fill), d_i [W-1:0] (parallel data), lsb_o (current serial bit).
module piso_register #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] d_i,
   output logic         lsb_o
);

   logic [W-1:0] data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          data_q <= '0;
      else if (load_i)  data_q <= d_i;
      else if (shift_i) data_q <= data_q >> 1;
   end

   assign lsb_o = data_q[0];

endmodule

// File: rtl/serial_adder_core.sv
// serial_adder_core: bit-serial add engine, LSB first, final carry emitted as the last bit.
// Ports: clk, rst (async, active-high), start (accepted only in IDLE), op_a/op_b [WIDTH-1:0]
//        (captured on the accepting edge), sub (only with SERIAL_SUB_EN: A-B instead of A+B),
//        sum_bit (serial result bit), sum_valid (shift enable for the downstream register),
//        busy (not IDLE), done (one-cycle pulse after the carry bit).
// Build option: define SERIAL_SUB_EN to add the sub port and two's-complement subtraction.
module serial_adder_core
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             sum_bit,
   output logic             sum_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = cnt_width(WIDTH);

   state_e          state_q, state_d;
   logic            carry_q, carry_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            a_bit, b_bit;
   logic            accept, adding;
   logic [WIDTH-1:0] b_load;
   logic            carry_init;

   // Subtraction is A + ~B + 1: invert B on load and seed the carry with 1.
`ifdef SERIAL_SUB_EN
   assign b_load     = sub ? ~op_b : op_b;
   assign carry_init = sub;
`else
   assign b_load     = op_b;
   assign carry_init = 1'b0;
`endif

   assign accept = (state_q == IDLE) && start;
   assign adding = (state_q == ADD);

   piso_register #(.W(WIDTH)) u_a_reg (
      .clk     (clk),
      .rst     (rst),
      .load_i  (accept),
      .shift_i (adding),
      .d_i     (op_a),
      .lsb_o   (a_bit)
   );

   piso_register #(.W(WIDTH)) u_b_reg (
      .clk     (clk),
      .rst     (rst),
      .load_i  (accept),
      .shift_i (adding),
      .d_i     (b_load),
      .lsb_o   (b_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      carry_d   = carry_q;
      cnt_d     = cnt_q;
      sum_bit   = 1'b0;
      sum_valid = 1'b0;
      busy      = (state_q != IDLE);
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ADD;
               carry_d = carry_init;
               cnt_d   = '0;
            end
         end
         ADD: begin
            sum_bit   = a_bit ^ b_bit ^ carry_q;
            sum_valid = 1'b1;
            carry_d   = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
            // The counter parks at WIDTH-1 on the last bit instead of wrapping.
            if (cnt_q == CW'(WIDTH - 1)) state_d = CARRY;
            else                         cnt_d   = cnt_q + 1'b1;
         end
         CARRY: begin
            sum_bit   = carry_q;
            sum_valid = 1'b1;
            state_d   = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_adder_core.sv
// tb_serial_adder_core: directed self-checking bench with a cycle-timeline model of the adder.
module tb_serial_adder_core;

   localparam int W = 8;
`ifdef SERIAL_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         sum_bit, sum_valid, busy, done;

   int           errs = 0;
   int           checks = 0;

   // Model: k = cycles since the accepting edge (0 = idle); res_m = expected {carry, sum}.
   int           k = 0;
   int           cyc = 0;
   logic [W:0]   res_m = '0;
   int           acc_cyc[$];
   // Downstream result register: shifts sum_bit in at the MSB while sum_valid.
   logic [W:0]   dreg = '0;
   logic         sub_eff;

   assign sub_eff = sub & SUB_EN;

   serial_adder_core #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op_a      (op_a),
      .op_b      (op_b),
`ifdef SERIAL_SUB_EN
      .sub       (sub),
`endif
      .sum_bit   (sum_bit),
      .sum_valid (sum_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) k <= 0;
      else begin
         cyc <= cyc + 1;
         if (k == 0) begin
            if (start) begin
               res_m <= {1'b0, op_a} + {1'b0, (sub_eff ? ~op_b : op_b)} + (W + 1)'(sub_eff);
               k     <= 1;
               acc_cyc.push_back(cyc);
            end
         end else k <= (k == W + 2) ? 0 : k + 1;
      end
   end

   always @(negedge clk) begin
      chk("sum_valid", sum_valid, (k >= 1 && k <= W + 1));
      chk("sum_bit", sum_bit, (k >= 1 && k <= W + 1) ? res_m[k-1] : 1'b0);
      chk("busy", busy, k != 0);
      chk("done", done, k == W + 2);
      if (sum_valid) dreg <= {sum_bit, dreg[W:1]};
   end

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_timeout"}, n < 20, 1'b1);
   endtask

   task automatic run(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic [W:0] exp);
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      sub   = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op_a  = ~a;
      op_b  = ~b;
      sub   = ~s;
      wait_done(name);
      chk(name, dreg, exp);
   endtask

   initial begin
      start = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("rst_async_busy", busy, 0);
      chk("rst_async_valid", sum_valid, 0);
      chk("rst_async_done", done, 0);
      chk("rst_async_bit", sum_bit, 0);
      repeat (3) @(negedge clk);
      chk("rst_hold_busy", busy, 0);
      rst   = 1'b0;
      start = 1'b0;

      run("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 9'h096);
      run("add_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100);
      run("add_00_00", 8'h00, 8'h00, 1'b0, 9'h000);

      @(negedge clk);
      op_a  = 8'h5A;
      op_b  = 8'h3C;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      op_a  = 8'hFF;
      op_b  = 8'hFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignore_add");
      chk("ignore_add", dreg, 9'h096);
      op_a  = 8'h01;
      op_b  = 8'h02;
      start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done("b2b");
      chk("b2b_result", dreg, 9'h003);
      chk("issue_interval", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], 11);

      @(negedge clk);
      op_a  = 8'h77;
      op_b  = 8'h11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_valid", sum_valid, 0);
      chk("abort_bit", sum_bit, 0);
      @(negedge clk);
      rst = 1'b0;
      run("after_abort", 8'h01, 8'h01, 1'b0, 9'h002);

`ifdef SERIAL_SUB_EN
      run("sub_10_01", 8'h10, 8'h01, 1'b1, 9'h10F);
      run("sub_01_02", 8'h01, 8'h02, 1'b1, 9'h0FF);
`endif

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
